// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache refill path: default geometry,
// set/tag width helpers and the refill FSM state encoding.
package cache_pkg;

  localparam int NUM_SET_DEFAULT = 8;

  // Number of index bits needed for a given number of cache sets.
  function automatic int set_w(input int num_set);
    return $clog2(num_set);
  endfunction

  // Tag width: 30 word-address bits minus the index bits.
  function automatic int tag_w(input int num_set);
    return 30 - $clog2(num_set);
  endfunction

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    FILL    = 3'd3,
    WR_REQ  = 3'd4
  } refill_state_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the Memory-stage, memory-request and cache-fill signals seen by
// the refill controller.
//
// Handshake: a request transfers on a rising clk edge where both
// mem_req_valid and mem_req_ready are high. Once valid is raised the
// controller keeps we/addr/wdata unchanged and valid high until that
// transfer; valid never drops without ready. mem_rsp_valid has no ready:
// the controller takes the word in the single cycle it is high.
interface cache_refill_ctrl_if #(
  parameter int NUM_SET = cache_pkg::NUM_SET_DEFAULT
);
  import cache_pkg::*;

  localparam int SET_W = set_w(NUM_SET);
  localparam int TAG_W = tag_w(NUM_SET);

  // Memory stage / cache lookup
  logic              MemReadM;
  logic              MemWriteM;
  logic [31:0]       ALUResultM;
  logic [31:0]       WriteDataM;
  logic              Hit;
  logic              StallM;
  // Request channel to data memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [31:0]       mem_req_addr;
  logic [31:0]       mem_req_wdata;
  // Read response from data memory
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  // Fill port into the cache
  logic              fill_en;
  logic [SET_W-1:0]  fill_set;
  logic [TAG_W-1:0]  fill_tag;
  logic [31:0]       fill_data;

  // Controller side
  modport master (
    input  MemReadM, MemWriteM, ALUResultM, WriteDataM, Hit,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output StallM,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output fill_en, fill_set, fill_tag, fill_data
  );

  // Pipeline / memory / cache side
  modport slave (
    output MemReadM, MemWriteM, ALUResultM, WriteDataM, Hit,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  StallM,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  fill_en, fill_set, fill_tag, fill_data
  );

endinterface

// File: rtl/cache_refill_ctrl_stats.sv
// Hit/miss counters for the refill controller. Present only when
// CACHE_REFILL_STATS_EN is defined.
`ifdef CACHE_REFILL_STATS_EN
module cache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_evt,   // IDLE with a load that hits
  input  logic        miss_evt,  // IDLE -> RD_REQ transition
  input  logic        fill_evt,  // controller is in FILL
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  logic refilled_q;

  // Flag the cycle after FILL: the replayed load hits then but was a miss.
  always_ff @(posedge clk) begin
    if (rst) refilled_q <= 1'b0;
    else     refilled_q <= fill_evt;
  end

  // Wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_evt && !refilled_q) hit_count  <= hit_count + 32'd1;
      if (miss_evt)               miss_count <= miss_count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/cache_refill_ctrl.sv
// Miss-handling / write-through controller between the direct-mapped data
// cache and data memory. Stalls the pipeline on a read miss or a store,
// fetches missing words and installs them through the fill port, and
// forwards every store to memory.
// Optional feature macro: CACHE_REFILL_STATS_EN adds hit_count/miss_count.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_SET = NUM_SET_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_refill_ctrl_if.master   bus,
  output refill_state_t         state_dbg
`ifdef CACHE_REFILL_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int SET_W = set_w(NUM_SET);

  refill_state_t state_q, state_d;

  logic [29:0] addr_q;     // captured word address (byte address bits 31:2)
  logic [31:0] wdata_q;    // captured store data
  logic [31:0] rdata_q;    // word returned by memory
  logic        wr_start;
  logic        rd_start;
  logic        unused_offset_bits;

  // Stores win over loads when both are flagged in the same cycle.
  assign wr_start = bus.MemWriteM;
  assign rd_start = !bus.MemWriteM && bus.MemReadM && !bus.Hit;

  // Word access only: the byte offset is dropped.
  assign unused_offset_bits = ^bus.ALUResultM[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_start)      state_d = WR_REQ;
        else if (rd_start) state_d = RD_REQ;
      end
      WR_REQ:  if (bus.mem_req_ready) state_d = IDLE;
      RD_REQ:  if (bus.mem_req_ready) state_d = RD_WAIT;
      RD_WAIT: if (bus.mem_rsp_valid) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture request fields when leaving IDLE and the read word in RD_WAIT;
  // the request outputs come straight from these so they stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (state_q == IDLE && (wr_start || rd_start)) addr_q <= bus.ALUResultM[31:2];
      if (state_q == IDLE && wr_start)               wdata_q <= bus.WriteDataM;
      if (state_q == RD_WAIT && bus.mem_rsp_valid)   rdata_q <= bus.mem_rsp_data;
    end
  end

  // Per-state outputs: stall, request strobe/direction and fill strobe.
  always_comb begin
    bus.StallM        = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.fill_en       = 1'b0;
    case (state_q)
      IDLE: begin
        bus.StallM = bus.MemWriteM || (bus.MemReadM && !bus.Hit);
      end
      WR_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        // The store retires on the edge memory accepts it.
        bus.StallM        = !bus.mem_req_ready;
      end
      RD_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.StallM        = 1'b1;
      end
      RD_WAIT: begin
        bus.StallM = 1'b1;
      end
      FILL: begin
        bus.fill_en = 1'b1;
        bus.StallM  = 1'b1;
      end
      default: begin
        bus.StallM = 1'b1;
      end
    endcase
  end

  assign bus.mem_req_addr  = {addr_q, 2'b00};
  assign bus.mem_req_wdata = wdata_q;
  assign bus.fill_set      = addr_q[SET_W-1:0];
  assign bus.fill_tag      = addr_q[29:SET_W];
  assign bus.fill_data     = rdata_q;
  assign state_dbg         = state_q;

`ifdef CACHE_REFILL_STATS_EN
  cache_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .hit_evt    (state_q == IDLE && bus.MemReadM && bus.Hit),
    .miss_evt   (state_q == IDLE && rd_start),
    .fill_evt   (state_q == FILL),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl. Honors CACHE_REFILL_STATS_EN.
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  localparam int NUM_SET = 8;
  localparam int SET_W   = set_w(NUM_SET);
  localparam int TAG_W   = tag_w(NUM_SET);
  localparam int RW      = 65;                 // {we, addr, wdata}
  localparam int FW      = SET_W + TAG_W + 32; // {set, tag, data}

  logic          clk;
  logic          rst;
  refill_state_t state_dbg;
`ifdef CACHE_REFILL_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  cache_refill_ctrl_if #(.NUM_SET(NUM_SET)) bus_if();

  cache_refill_ctrl #(.NUM_SET(NUM_SET)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .state_dbg  (state_dbg)
`ifdef CACHE_REFILL_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  logic [FW-1:0] fill_q[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: requests and fills are checked as the DUT produces them.
  always @(negedge clk) begin
    logic [RW-1:0] er;
    logic [FW-1:0] ef;
    #2;
    if (!rst && bus_if.mem_req_valid && bus_if.mem_req_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL req_unexpected: addr 0x%08h accepted, none expected", bus_if.mem_req_addr);
      end else begin
        er = exp_q.pop_front();
        chk("req_we", 32'(bus_if.mem_req_we), 32'(er[64]));
        chk("req_addr", bus_if.mem_req_addr, er[63:32]);
        if (er[64]) chk("req_wdata", bus_if.mem_req_wdata, er[31:0]);
      end
    end
    if (!rst && bus_if.fill_en) begin
      if (fill_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL fill_unexpected: fill_en high, none expected at %0t", $time);
      end else begin
        ef = fill_q.pop_front();
        chk("fill_set", 32'(bus_if.fill_set), 32'(ef[FW-1:TAG_W+32]));
        chk("fill_tag", 32'(bus_if.fill_tag), 32'(ef[TAG_W+31:32]));
        chk("fill_data", bus_if.fill_data, ef[31:0]);
      end
    end
  end

  // Driver tasks: inputs change on the falling edge, outputs sampled 1 later.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_if.MemReadM = 1'b0; bus_if.MemWriteM = 1'b0; bus_if.Hit = 1'b0;
    bus_if.mem_req_ready = 1'b0; bus_if.mem_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_req_addr", bus_if.mem_req_addr, 32'h0);
    chk("rst_req_wdata", bus_if.mem_req_wdata, 32'h0);
    chk("rst_fill_data", bus_if.fill_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
  endtask

  task automatic do_read_miss(input logic [31:0] addr, input logic [31:0] data,
                              input int ready_dly, input int rsp_dly, input logic spurious,
                              input logic [SET_W-1:0] exp_set, input logic [TAG_W-1:0] exp_tag);
    @(negedge clk);
    rst = 1'b0;  // ends a preceding reset phase, if any
    bus_if.MemReadM = 1'b1; bus_if.MemWriteM = 1'b0; bus_if.Hit = 1'b0;
    bus_if.ALUResultM = addr;
    bus_if.mem_req_ready = 1'b0; bus_if.mem_rsp_valid = 1'b0;
    exp_q.push_back({1'b0, addr & 32'hFFFF_FFFC, 32'h0});
    #1;
    chk("rd_stall_idle", 32'(bus_if.StallM), 32'd1);
    chk("rd_state_idle", 32'(state_dbg), 32'(IDLE));
    for (int i = 0; i < ready_dly; i++) begin
      @(negedge clk);
      bus_if.mem_rsp_valid = spurious;
      bus_if.mem_rsp_data  = ~data;
      #1;
      chk("rd_req_valid_wait", 32'(bus_if.mem_req_valid), 32'd1);
      chk("rd_req_addr_wait", bus_if.mem_req_addr, addr & 32'hFFFF_FFFC);
      chk("rd_state_req", 32'(state_dbg), 32'(RD_REQ));
    end
    @(negedge clk);
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_req_ready = 1'b1;
    #1;
    chk("rd_req_valid", 32'(bus_if.mem_req_valid), 32'd1);
    chk("rd_req_we", 32'(bus_if.mem_req_we), 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      bus_if.mem_req_ready = 1'b0;
      #1;
      chk("rd_wait_valid", 32'(bus_if.mem_req_valid), 32'd0);
      chk("rd_wait_stall", 32'(bus_if.StallM), 32'd1);
    end
    @(negedge clk);
    bus_if.mem_req_ready = 1'b0;
    bus_if.mem_rsp_valid = 1'b1;
    bus_if.mem_rsp_data  = data;
    fill_q.push_back({exp_set, exp_tag, data});
    #1;
    chk("rd_state_wait", 32'(state_dbg), 32'(RD_WAIT));
    @(negedge clk);
    bus_if.mem_rsp_valid = 1'b0;
    bus_if.mem_rsp_data  = 32'h0;
    #1;
    chk("fill_en", 32'(bus_if.fill_en), 32'd1);
    chk("fill_stall", 32'(bus_if.StallM), 32'd1);
    @(negedge clk);
    bus_if.Hit = 1'b1;  // cache installed the word
    #1;
    chk("after_fill_stall", 32'(bus_if.StallM), 32'd0);
    chk("after_fill_state", 32'(state_dbg), 32'(IDLE));
    chk("after_fill_en", 32'(bus_if.fill_en), 32'd0);
    @(negedge clk);
    bus_if.MemReadM = 1'b0; bus_if.Hit = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int ready_dly);
    @(negedge clk);
    bus_if.MemWriteM = 1'b1; bus_if.MemReadM = 1'b0; bus_if.Hit = 1'b0;
    bus_if.ALUResultM = addr; bus_if.WriteDataM = data;
    bus_if.mem_req_ready = 1'b0;
    exp_q.push_back({1'b1, addr & 32'hFFFF_FFFC, data});
    #1;
    chk("wr_stall_idle", 32'(bus_if.StallM), 32'd1);
    for (int i = 0; i < ready_dly; i++) begin
      @(negedge clk);
      bus_if.ALUResultM = $urandom;  // captured fields must not follow these
      bus_if.WriteDataM = $urandom;
      #1;
      chk("wr_valid_wait", 32'(bus_if.mem_req_valid), 32'd1);
      chk("wr_we_wait", 32'(bus_if.mem_req_we), 32'd1);
      chk("wr_addr_wait", bus_if.mem_req_addr, addr & 32'hFFFF_FFFC);
      chk("wr_wdata_wait", bus_if.mem_req_wdata, data);
      chk("wr_stall_wait", 32'(bus_if.StallM), 32'd1);
    end
    @(negedge clk);
    bus_if.mem_req_ready = 1'b1;
    #1;
    chk("wr_stall_ready", 32'(bus_if.StallM), 32'd0);
    chk("wr_valid_ready", 32'(bus_if.mem_req_valid), 32'd1);
    @(negedge clk);
    bus_if.MemWriteM = 1'b0; bus_if.mem_req_ready = 1'b0;
    #1;
    chk("wr_done_state", 32'(state_dbg), 32'(IDLE));
    chk("wr_done_valid", 32'(bus_if.mem_req_valid), 32'd0);
  endtask

  typedef struct packed {
    logic rd;
    logic wr;
    logic hit;
    logic stall;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{rd: 1'b0, wr: 1'b0, hit: 1'b0, stall: 1'b0};
    vecs[1] = '{rd: 1'b0, wr: 1'b0, hit: 1'b1, stall: 1'b0};
    vecs[2] = '{rd: 1'b1, wr: 1'b0, hit: 1'b0, stall: 1'b1};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, hit: 1'b1, stall: 1'b0};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, hit: 1'b0, stall: 1'b1};
    vecs[5] = '{rd: 1'b0, wr: 1'b1, hit: 1'b1, stall: 1'b1};
    vecs[6] = '{rd: 1'b1, wr: 1'b1, hit: 1'b0, stall: 1'b1};
    vecs[7] = '{rd: 1'b1, wr: 1'b1, hit: 1'b1, stall: 1'b1};

    rst = 1'b1;
    bus_if.MemReadM = 1'b1; bus_if.MemWriteM = 1'b0; bus_if.Hit = 1'b0;
    bus_if.ALUResultM = 32'h0000_0104; bus_if.WriteDataM = 32'h0;
    bus_if.mem_req_ready = 1'b0; bus_if.mem_rsp_valid = 1'b0; bus_if.mem_rsp_data = 32'h0;

    // Reset held two cycles with a pending miss on the inputs.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_valid", 32'(bus_if.mem_req_valid), 32'd0);
      chk("rst_fill_en", 32'(bus_if.fill_en), 32'd0);
      chk("rst_state_hold", 32'(state_dbg), 32'(IDLE));
    end
    chk("rst_we", 32'(bus_if.mem_req_we), 32'd0);
    chk("rst_fill_set", 32'(bus_if.fill_set), 32'd0);
    chk("rst_fill_tag", 32'(bus_if.fill_tag), 32'd0);
    chk("rst_addr", bus_if.mem_req_addr, 32'h0);
    // The miss proceeds once reset is released.
    do_read_miss(32'h0000_0104, 32'h5555_AAAA, 0, 0, 1'b0, 3'd1, 27'd8);

    // Combinational stall decode in IDLE; inputs withdrawn before each edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_if.MemReadM = vecs[i].rd; bus_if.MemWriteM = vecs[i].wr; bus_if.Hit = vecs[i].hit;
      #1;
      chk($sformatf("tbl_stall_%0d", i), 32'(bus_if.StallM), 32'(vecs[i].stall));
      chk($sformatf("tbl_valid_%0d", i), 32'(bus_if.mem_req_valid), 32'd0);
      bus_if.MemReadM = 1'b0; bus_if.MemWriteM = 1'b0; bus_if.Hit = 1'b0;
    end

    // Load miss, ready immediate, response three cycles after acceptance.
    do_read_miss(32'h0000_0024, 32'hDEAD_BEEF, 0, 2, 1'b0, 3'd1, 27'd1);

    // Stores: delayed ready, then immediate ready with an unaligned address.
    do_store(32'h0000_0040, 32'h1234_5678, 2);
    do_store(32'h0000_0047, 32'hA5A5_0001, 0);

    // Load hit after a fresh reset: no request, no stall.
    do_reset();
    @(negedge clk);
    bus_if.MemReadM = 1'b1; bus_if.Hit = 1'b1; bus_if.ALUResultM = 32'h0000_0300;
    #1;
    chk("hit_stall", 32'(bus_if.StallM), 32'd0);
    @(negedge clk);
    bus_if.MemReadM = 1'b0; bus_if.Hit = 1'b0;
    #1;
    chk("hit_state", 32'(state_dbg), 32'(IDLE));
    chk("hit_valid", 32'(bus_if.mem_req_valid), 32'd0);
`ifdef CACHE_REFILL_STATS_EN
    chk("hit_count_1", hit_count, 32'd1);
    chk("miss_count_0", miss_count, 32'd0);
`endif

    // Spurious response in IDLE.
    @(negedge clk);
    bus_if.mem_rsp_valid = 1'b1; bus_if.mem_rsp_data = 32'hFFFF_0000;
    @(negedge clk);
    bus_if.mem_rsp_valid = 1'b0;
    #1;
    chk("spur_idle_fill", 32'(bus_if.fill_en), 32'd0);
    chk("spur_idle_state", 32'(state_dbg), 32'(IDLE));

    // Spurious response while the read request waits for ready.
    do_read_miss(32'h0000_0088, 32'h0BAD_CAFE, 2, 1, 1'b1, 3'd2, 27'd4);

    // Reset during RD_WAIT abandons the read.
    @(negedge clk);
    bus_if.MemReadM = 1'b1; bus_if.Hit = 1'b0; bus_if.ALUResultM = 32'h0000_0200;
    exp_q.push_back({1'b0, 32'h0000_0200, 32'h0});
    @(negedge clk);
    bus_if.mem_req_ready = 1'b1;
    @(negedge clk);
    bus_if.mem_req_ready = 1'b0; rst = 1'b1;
    #1;
    chk("abort_state_wait", 32'(state_dbg), 32'(RD_WAIT));
    @(negedge clk);
    rst = 1'b0; bus_if.MemReadM = 1'b0;
    #1;
    chk("abort_state_idle", 32'(state_dbg), 32'(IDLE));
    chk("abort_valid", 32'(bus_if.mem_req_valid), 32'd0);
    chk("abort_stall", 32'(bus_if.StallM), 32'd0);

    // A new miss after the abort fills correctly.
    do_read_miss(32'h0000_1238, 32'hCAFE_F00D, 1, 0, 1'b0, 3'd6, 27'h91);
`ifdef CACHE_REFILL_STATS_EN
    #1;
    chk("end_hit_count", hit_count, 32'd0);
    chk("end_miss_count", miss_count, 32'd1);
`endif

    repeat (2) @(negedge clk);
    chk("req_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("fill_queue_empty", 32'(fill_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
